pc_next_sel_reg: RTL and testbench
==================================

Name: pc_next_sel_reg

Overview:
- Parametrised successor to the datapath's next-PC source selector: N-way source select, width-generic, plus the PC register itself.
- Adds a write-enable/branch-condition gate and a three-state exception sequencer that captures EPC and cause, then redirects the PC to a fixed vector.
- Sits between the ALU/shift/EPC/MDR result buses and the instruction-address port, and is driven by the control unit.

Parameters:
- WIDTH, 32, PC/data width in bits.
- NUM_SRC, 8, number of selectable next-PC sources (>=2).
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= NUM_SRC.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- VEC_OPC, 32'h0000_00FD, redirect vector for the invalid-opcode exception.
- VEC_OVF, 32'h0000_00FE, redirect vector for the overflow exception.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_data  in  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  source index.
- pc_write  in  1  unconditional PC load.
- pc_write_cond  in  1  conditional PC load, qualified by cond_true.
- cond_true  in  1  branch condition from the ALU flags.
- exc_opc  in  1  invalid-opcode exception request (level, sampled).
- exc_ovf  in  1  overflow exception request (level, sampled).
- pc  out  WIDTH  current PC register.
- epc  out  WIDTH  exception PC register.
- cause  out  2  01 = opcode, 10 = overflow, 00 = none yet.
- exc_busy  out  1  high while the sequencer is not in RUN.
- pc_updated  out  1  one-cycle pulse on the cycle after any PC register load.

Behaviour:
Reset:
- reset_n low asynchronously sets: pc = RESET_PC, epc = 0, cause = 00, state = RUN, exc_busy = 0, pc_updated = 0.
- Reset asserted mid-sequence aborts the sequence immediately; no partial EPC/PC update survives.

Source select:
- Combinational next value nxt = src_data[sel].
- If sel >= NUM_SRC, nxt = source NUM_SRC-1 (legacy default-to-last behaviour).

Load enable:
- ld = pc_write | (pc_write_cond & cond_true).

State machine (states RUN, EXC_SAVE, EXC_JUMP):
- RUN, neither exc_* high:
  - ld = 1: pc <= nxt.
  - ld = 0: pc holds.
- RUN, exc_opc or exc_ovf high:
  - Latch cause; opc has priority if both are high.
  - pc does not load, even if ld = 1 that cycle.
  - Go to EXC_SAVE.
- EXC_SAVE:
  - epc <= pc (address of the faulting instruction as currently held).
  - Go to EXC_JUMP.
- EXC_JUMP:
  - pc <= VEC_OPC or VEC_OVF according to the latched cause.
  - Go to RUN.
- exc_busy = 1 in EXC_SAVE and EXC_JUMP.
  - ld and exc_* inputs are ignored in those states.
  - An exception still asserted on return to RUN starts a new sequence.
- Total redirect latency: vector visible on pc 3 edges after the request is sampled.

Outputs and arithmetic:
- cause and epc hold their values until the next exception; they are never cleared except by reset.
- Return from exception is an ordinary load: the control unit routes epc into a source slot and asserts pc_write.
- pc_updated is registered: 1 on the cycle following any edge at which pc was written (ld load or vector load), otherwise 0.
  - Back-to-back loads give back-to-back pulses.
- No arithmetic on the PC inside the block. Values are loaded verbatim at WIDTH bits, with no truncation or extension.

Test Plan:
- Reset release, then sel = 2, src2 = 32'h0000_0040, pc_write = 1 for one cycle -> pc = 32'h40 after 1 edge; pc_updated = 1 the next cycle, then 0.
- pc_write_cond = 1, cond_true = 0, sel = 1, src1 = 32'h100 -> pc unchanged, no pulse. Repeat with cond_true = 1 -> pc = 32'h100.
- pc = 32'h20, exc_ovf = 1 for one cycle, pc_write = 1 in the same cycle -> pc not loaded from source. Then:
  - exc_busy high for 2 cycles;
  - epc = 32'h20;
  - cause = 10;
  - pc = 32'hFE on the 3rd edge.
- exc_opc and exc_ovf both high -> cause = 01, pc = 32'hFD. Any exc_* or pc_write pulsed during busy -> no effect.
- NUM_SRC = 5, sel = 7, src4 = 32'hABC, pc_write = 1 -> pc = 32'hABC.
- reset_n pulsed low while in EXC_SAVE -> pc = RESET_PC, epc = 0, cause = 00, exc_busy = 0, asynchronously before the next edge.

Source files
------------

// File: rtl/pc_next_sel_reg.sv
// Next-PC source selector plus PC register with a three-step exception
// sequencer (capture cause -> save EPC -> jump to the fixed vector).
module pc_next_sel_reg #(
  parameter int               WIDTH    = 32,
  parameter int               NUM_SRC  = 8,
  parameter int               SEL_W    = 3,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] VEC_OPC  = WIDTH'(32'h0000_00FD),
  parameter logic [WIDTH-1:0] VEC_OVF  = WIDTH'(32'h0000_00FE)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic                     exc_opc,
  input  logic                     exc_ovf,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         epc,
  output logic [1:0]               cause,
  output logic                     exc_busy,
  output logic                     pc_updated
);

  typedef enum logic [1:0] {RUN, EXC_SAVE, EXC_JUMP} state_t;

  localparam logic [1:0] CAUSE_OPC = 2'b01;
  localparam logic [1:0] CAUSE_OVF = 2'b10;

  state_t                          state;
  logic [NUM_SRC-1:0][WIDTH-1:0]   src;
  logic [WIDTH-1:0]                nxt;
  logic                            ld;
  logic                            exc_req;

  // Split the flat source bus into one word per slot.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src[g] = src_data[g*WIDTH +: WIDTH];
  end

  // Source mux; any out-of-range selector falls through to the last slot.
  always_comb begin
    nxt = src[NUM_SRC-1];
    for (int i = 0; i < NUM_SRC-1; i++)
      if (sel == SEL_W'(i)) nxt = src[i];
  end

  assign ld      = pc_write | (pc_write_cond & cond_true);
  assign exc_req = exc_opc | exc_ovf;

  // PC register and exception sequencer; exceptions pre-empt a same-cycle load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      epc        <= '0;
      cause      <= 2'b00;
      exc_busy   <= 1'b0;
      pc_updated <= 1'b0;
    end else begin
      pc_updated <= 1'b0;
      case (state)
        RUN: begin
          if (exc_req) begin
            cause    <= exc_opc ? CAUSE_OPC : CAUSE_OVF;
            exc_busy <= 1'b1;
            state    <= EXC_SAVE;
          end else if (ld) begin
            pc         <= nxt;
            pc_updated <= 1'b1;
          end
        end
        EXC_SAVE: begin
          epc   <= pc;
          state <= EXC_JUMP;
        end
        EXC_JUMP: begin
          pc         <= (cause == CAUSE_OPC) ? VEC_OPC : VEC_OVF;
          pc_updated <= 1'b1;
          exc_busy   <= 1'b0;
          state      <= RUN;
        end
        default: begin
          exc_busy <= 1'b0;
          state    <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_sel_reg.sv
// Bench: directed plan items then random traffic, checked by a scoreboard
// fed from a countdown-based reference model.
module tb_pc_next_sel_reg;

  localparam int NS = 5;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NS*W-1:0] src_data;
  logic [2:0]      sel;
  logic            pc_write, pc_write_cond, cond_true, exc_opc, exc_ovf;
  logic [W-1:0]    pc, epc;
  logic [1:0]      cause;
  logic            exc_busy, pc_updated;

  pc_next_sel_reg #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .sel(sel),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
    .exc_opc(exc_opc), .exc_ovf(exc_ovf), .pc(pc), .epc(epc), .cause(cause),
    .exc_busy(exc_busy), .pc_updated(pc_updated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        busy;
    logic        upd;
  } exp_t;

  exp_t        expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] srcw [NS];

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  int          m_left;   // cycles of exception sequence remaining
  logic        m_upd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    srcw[i] = v;
    src_data[i*W +: W] = v;
  endtask

  task automatic drive(input logic pw, input logic pwc, input logic ct,
                       input logic [2:0] s, input logic eo, input logic ev);
    pc_write = pw; pc_write_cond = pwc; cond_true = ct;
    sel = s; exc_opc = eo; exc_ovf = ev;
  endtask

  // Model one clock edge from the inputs currently applied.
  task automatic model_edge();
    int idx;
    if (!reset_n) begin
      m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00; m_left = 0; m_upd = 1'b0;
      return;
    end
    m_upd = 1'b0;
    if (m_left == 2) begin
      m_epc  = m_pc;
      m_left = 1;
    end else if (m_left == 1) begin
      m_pc   = (m_cause == 2'b01) ? 32'hFD : 32'hFE;
      m_upd  = 1'b1;
      m_left = 0;
    end else if (exc_opc || exc_ovf) begin
      m_cause = exc_opc ? 2'b01 : 2'b10;
      m_left  = 2;
    end else if (pc_write || (pc_write_cond && cond_true)) begin
      idx   = (int'(sel) < NS) ? int'(sel) : NS-1;
      m_pc  = srcw[idx];
      m_upd = 1'b1;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.pc = m_pc; e.epc = m_epc; e.cause = m_cause; e.busy = (m_left != 0); e.upd = m_upd;
    expq.push_back(e);
    #1;
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("pc",         pc,                 e.pc);
        check("epc",        epc,                e.epc);
        check("cause",      32'(cause),         32'(e.cause));
        check("exc_busy",   32'(exc_busy),      32'(e.busy));
        check("pc_updated", 32'(pc_updated),    32'(e.upd));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    src_data = '0;
    for (int i = 0; i < NS; i++) srcw[i] = 32'h0;
    drive(0, 0, 0, 3'd0, 0, 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // unconditional load then pulse decay
    set_src(2, 32'h40);
    drive(1, 0, 0, 3'd2, 0, 0); step();
    drive(0, 0, 0, 3'd2, 0, 0); step(); step();

    // conditional load, blocked then taken
    set_src(1, 32'h100);
    drive(0, 1, 0, 3'd1, 0, 0); step();
    drive(0, 1, 1, 3'd1, 0, 0); step();
    drive(0, 0, 0, 3'd1, 0, 0); step(); step();

    // overflow exception with simultaneous load
    set_src(0, 32'h20);
    drive(1, 0, 0, 3'd0, 0, 0); step();
    drive(1, 0, 0, 3'd1, 0, 1); step();
    drive(0, 0, 0, 3'd0, 0, 0); repeat (3) step();

    // both exceptions; inputs pulsed while busy must be ignored
    drive(0, 0, 0, 3'd0, 1, 1); step();
    drive(1, 1, 1, 3'd1, 0, 1); step();
    drive(1, 0, 0, 3'd2, 1, 0); step();
    drive(0, 0, 0, 3'd0, 0, 0); repeat (2) step();

    // back-to-back loads
    drive(1, 0, 0, 3'd1, 0, 0); step();
    drive(1, 0, 0, 3'd2, 0, 0); step();

    // out-of-range selector defaults to the last slot
    set_src(4, 32'hABC);
    drive(1, 0, 0, 3'd7, 0, 0); step();
    drive(1, 0, 0, 3'd5, 0, 0); step();
    drive(0, 0, 0, 3'd0, 0, 0); step();

    // async reset while in EXC_SAVE
    set_src(3, 32'h55);
    drive(1, 0, 0, 3'd3, 0, 0); step();
    drive(0, 0, 0, 3'd0, 0, 1); step();
    drive(0, 0, 0, 3'd0, 0, 0);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_pc",    pc,                 32'h0);
    check("rst_epc",   epc,                32'h0);
    check("rst_cause", 32'(cause),         32'h0);
    check("rst_busy",  32'(exc_busy),      32'h0);
    check("rst_upd",   32'(pc_updated),    32'h0);
    step();
    reset_n = 1'b1;
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) set_src($urandom_range(0, NS-1), $urandom);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      step();
    end

    drive(0, 0, 0, 3'd0, 0, 0);
    repeat (2) step();
    @(negedge clk); #1;
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
